perf_overflow_irq: RTL and testbench
====================================

# perf_overflow_irq

Local-count-overflow interrupt block (Sscofpmf style) sitting directly downstream of the performance-counter unit. It tracks when each hardware performance counter wraps and holds one sticky overflow (OF) bit per counter. On the first overflow it raises the LCOFIP pending bit towards the CSR file's interrupt logic. It also exports the `scountovf` view of the OF bits for CSR reads.

## Interface
Parameters:
- `NumCounters`, default 6: number of hpm counters (mhpmcounter3 upward); legal range 1..29.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, **asynchronous, active-high**.
- `debug_mode_i` in 1: core is in debug mode.
- `wrap_i` in `NumCounters`: counter k incremented from all-ones to zero this cycle (carry out of the 64-bit counter).
- `of_we_i` in 1: software write of one OF bit (mhpmevent write).
- `of_idx_i` in 5: counter index of the write (0 = mhpmcounter3).
- `of_wdata_i` in 1: new OF value.
- `lcofip_we_i` in 1: software write of mip.LCOFIP.
- `lcofip_wdata_i` in 1: new LCOFIP value.
- `lcofie_i` in 1: mie.LCOFIE.
- `of_o` out `NumCounters`: current OF bits.
- `scountovf_o` out 32: `of_o[k]` placed at bit k+3; all other bits zero.
- `lcofip_o` out 1: LCOFIP pending bit.
- `irq_o` out 1: `lcofip_o & lcofie_i`; this is the only combinational output.

## Operation
- OF bit k is set by hardware on `wrap_i[k]` and is otherwise changed only by software writes.
- Software writes with `of_idx_i >= NumCounters` are ignored.
- **Rising OF:** a hardware set of a bit whose registered OF value was 0 sets LCOFIP. A wrap on a counter whose OF is already 1 has no effect on LCOFIP.
- **Mode FSM:**
  - States are RUN and HOLD. RUN -> HOLD when `debug_mode_i`=1; HOLD -> RUN when `debug_mode_i`=0.
  - In HOLD, wraps are recorded in a deferred mask `def_q` and do not change OF or LCOFIP.
  - On the HOLD -> RUN transition cycle, `def_q` is applied as though all its wraps occurred in that cycle, then `def_q` is cleared.
  - Software writes take effect in both states.
- **Priority for the same counter in the same cycle:** a hardware set wins over a software write of 0. The resulting OF is 1, and the rising-OF rule uses the registered value.
- **Priority for LCOFIP in the same cycle:** a hardware set wins over `lcofip_we_i` with data 0. Otherwise a software write sets or clears LCOFIP directly.
- Multiple simultaneous wraps are each handled independently for OF. They set LCOFIP if any of them is rising.

## Timing
- Values after reset: `of_o` = 0, `scountovf_o` = 0, `lcofip_o` = 0, `irq_o` = 0, `def_q` = 0, FSM in RUN.
- Latency: a wrap in cycle N gives `of_o`, `scountovf_o` and `lcofip_o` updated in cycle N+1. `irq_o` follows in N+1 if `lcofie_i` is high.
- A software write in cycle N is visible in cycle N+1.
- A `debug_mode_i` change in cycle N changes the state in N+1.
- There is no handshake. Everything is level/pulse, one event per counter per cycle.
- Reset asserted mid-operation clears all state immediately (asynchronously). This includes any pending deferred mask.

## Structure
- Add to `ariane_pkg`:
  - a `HPM_IDX_BASE = 3` constant;
  - a `perf_of_state_e` enum {RUN, HOLD}.
- `MHPMCounterNum` from `ariane_pkg` supplies the top-level value of `NumCounters`.
- No sub-module is needed. Use a single `always_comb` next-state block and a single `always_ff` block.
- Integration: the perf-counter unit computes `wrap_i` as the increment enable ANDed with the counter being all-ones.

## Test plan
- **Reset:** assert `rst_i` mid-cycle -> all outputs are 0 immediately and stay 0 for 3 cycles after release.
- **Single wrap:**
  - stimulus: `wrap_i[0]` pulse with `lcofie_i`=1;
  - next cycle: `of_o`=6'b000001, `scountovf_o`=32'h8, `lcofip_o`=1, `irq_o`=1;
  - a second `wrap_i[0]` after `lcofip_we_i`=1/`lcofip_wdata_i`=0 -> LCOFIP stays 0.
- **Simultaneous software write and wrap:**
  - stimulus: `of_we_i`, `of_idx_i`=2, `of_wdata_i`=0 in the same cycle as `wrap_i[2]`, with OF[2] previously 0;
  - response: OF[2]=1 and `lcofip_o`=1.
- **LCOFIP clear race:**
  - stimulus: `lcofip_we_i`=1/`lcofip_wdata_i`=0 in the same cycle as `wrap_i[5]` (OF[5] was 0);
  - response: `lcofip_o`=1 and `scountovf_o`=32'h100.
- **Debug hold:**
  - stimulus: `debug_mode_i`=1, then `wrap_i[1]` and `wrap_i[3]`;
  - in HOLD: `of_o` stays 0;
  - on exit from debug: `of_o`=6'b001010 and `lcofip_o`=1 one cycle after the RUN transition cycle.
- **Out-of-range write:**
  - `of_we_i`, `of_idx_i`=6, `of_wdata_i`=1 -> `of_o` unchanged;
  - `lcofie_i`=0 with a pending LCOFIP -> `irq_o`=0, `lcofip_o`=1.

Source files
------------

// File: rtl/perf_overflow_irq_pkg.sv
// Shared constants and types for the local-count-overflow interrupt block.
package perf_overflow_irq_pkg;

  localparam int unsigned HPM_IDX_BASE   = 3;
  localparam int unsigned MHPMCounterNum = 6;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } perf_of_state_e;

endpackage

// File: rtl/perf_overflow_irq_if.sv
// Signal bundle between the perf-counter/CSR side (master) and the overflow block (slave).
interface perf_overflow_irq_if
  import perf_overflow_irq_pkg::*;
#(
  parameter int unsigned NumCounters = MHPMCounterNum
) ();

  logic                   debug_mode_i;
  logic [NumCounters-1:0] wrap_i;
  logic                   of_we_i;
  logic [4:0]             of_idx_i;
  logic                   of_wdata_i;
  logic                   lcofip_we_i;
  logic                   lcofip_wdata_i;
  logic                   lcofie_i;
  logic [NumCounters-1:0] of_o;
  logic [31:0]            scountovf_o;
  logic                   lcofip_o;
  logic                   irq_o;

  modport master (
    output debug_mode_i, wrap_i, of_we_i, of_idx_i, of_wdata_i,
           lcofip_we_i, lcofip_wdata_i, lcofie_i,
    input  of_o, scountovf_o, lcofip_o, irq_o
  );

  modport slave (
    input  debug_mode_i, wrap_i, of_we_i, of_idx_i, of_wdata_i,
           lcofip_we_i, lcofip_wdata_i, lcofie_i,
    output of_o, scountovf_o, lcofip_o, irq_o
  );

endinterface

// File: rtl/perf_overflow_irq.sv
// Sticky per-counter overflow bits and the LCOFIP pending bit, with wraps
// deferred while the core sits in debug mode.
module perf_overflow_irq
  import perf_overflow_irq_pkg::*;
#(
  parameter int unsigned NumCounters = MHPMCounterNum
) (
  input logic                clk_i,
  input logic                rst_i,
  perf_overflow_irq_if.slave bus
);

  perf_of_state_e         state_q, state_d;
  logic [NumCounters-1:0] of_q, of_d;
  logic [NumCounters-1:0] def_q, def_d;
  logic [NumCounters-1:0] hw_set;
  logic                   lcofip_q, lcofip_d;

  always_comb begin
    state_d  = state_q;
    def_d    = '0;
    hw_set   = '0;
    of_d     = of_q;
    lcofip_d = lcofip_q;

    // Deferred wraps replay on the exit cycle together with any wrap of that cycle.
    unique case (state_q)
      RUN: begin
        hw_set = bus.wrap_i;
        if (bus.debug_mode_i) state_d = HOLD;
      end
      HOLD: begin
        if (bus.debug_mode_i) begin
          def_d = def_q | bus.wrap_i;
        end else begin
          hw_set  = def_q | bus.wrap_i;
          state_d = RUN;
        end
      end
    endcase

    for (int unsigned k = 0; k < NumCounters; k++) begin
      if (bus.of_we_i && (bus.of_idx_i == 5'(k))) of_d[k] = bus.of_wdata_i;
    end
    of_d = of_d | hw_set;

    // Only a 0->1 hardware set of the registered OF raises LCOFIP.
    if (|(hw_set & ~of_q))  lcofip_d = 1'b1;
    else if (bus.lcofip_we_i) lcofip_d = bus.lcofip_wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      of_q     <= '0;
      def_q    <= '0;
      lcofip_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      of_q     <= of_d;
      def_q    <= def_d;
      lcofip_q <= lcofip_d;
    end
  end

  assign bus.of_o        = of_q;
  assign bus.scountovf_o = 32'(of_q) << HPM_IDX_BASE;
  assign bus.lcofip_o    = lcofip_q;
  assign bus.irq_o       = lcofip_q & bus.lcofie_i;

endmodule

// File: tb/tb_perf_overflow_irq.sv
// Scoreboard bench for perf_overflow_irq: directed vectors push expected
// outputs, a monitor pops and compares one entry per clock.
module tb_perf_overflow_irq;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  perf_overflow_irq_if bus ();

  perf_overflow_irq dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  typedef struct {
    int          id;
    logic [5:0]  of_v;
    logic [31:0] sc_v;
    logic        lcofip_v;
    logic        irq_v;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " of"},        32'(bus.of_o),   32'h0);
    checkOutput({tag, " scountovf"}, bus.scountovf_o, 32'h0);
    checkOutput({tag, " lcofip"},    32'(bus.lcofip_o), 32'h0);
    checkOutput({tag, " irq"},       32'(bus.irq_o),  32'h0);
  endtask

  task automatic idleInputs();
    bus.debug_mode_i   = 1'b0;
    bus.wrap_i         = '0;
    bus.of_we_i        = 1'b0;
    bus.of_idx_i       = '0;
    bus.of_wdata_i     = 1'b0;
    bus.lcofip_we_i    = 1'b0;
    bus.lcofip_wdata_i = 1'b0;
    bus.lcofie_i       = 1'b0;
  endtask

  // Drives one cycle of inputs and queues the outputs expected after the next edge.
  task automatic applyStimulus(
    input logic       dbg,
    input logic [5:0] wrap,
    input logic       of_we, input logic [4:0] of_idx, input logic of_wdata,
    input logic       lp_we, input logic lp_wdata,
    input logic       lcofie,
    input logic [5:0] e_of, input logic [31:0] e_sc, input logic e_lp, input logic e_irq);
    exp_t e;
    @(negedge clk_i);
    bus.debug_mode_i   = dbg;
    bus.wrap_i         = wrap;
    bus.of_we_i        = of_we;
    bus.of_idx_i       = of_idx;
    bus.of_wdata_i     = of_wdata;
    bus.lcofip_we_i    = lp_we;
    bus.lcofip_wdata_i = lp_wdata;
    bus.lcofie_i       = lcofie;
    vec_id++;
    e.id = vec_id; e.of_v = e_of; e.sc_v = e_sc; e.lcofip_v = e_lp; e.irq_v = e_irq;
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput($sformatf("v%0d of", e.id),        32'(bus.of_o),     32'(e.of_v));
        checkOutput($sformatf("v%0d scountovf", e.id), bus.scountovf_o,   e.sc_v);
        checkOutput($sformatf("v%0d lcofip", e.id),    32'(bus.lcofip_o), 32'(e.lcofip_v));
        checkOutput($sformatf("v%0d irq", e.id),       32'(bus.irq_o),    32'(e.irq_v));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int drain;
    idleInputs();
    #2;
    checkAllZero("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    //             dbg wrap       we idx    wd lwe lwd ie  of         sc       lp   irq
    applyStimulus(0, 6'b000000, 0, 5'd0, 0, 0, 0, 1, 6'h00, 32'h000, 1'b0, 1'b0);
    applyStimulus(0, 6'b000001, 0, 5'd0, 0, 0, 0, 1, 6'h01, 32'h008, 1'b1, 1'b1);
    applyStimulus(0, 6'b000000, 0, 5'd0, 0, 1, 0, 1, 6'h01, 32'h008, 1'b0, 1'b0);
    applyStimulus(0, 6'b000001, 0, 5'd0, 0, 0, 0, 1, 6'h01, 32'h008, 1'b0, 1'b0);
    applyStimulus(0, 6'b000100, 1, 5'd2, 0, 0, 0, 1, 6'h05, 32'h028, 1'b1, 1'b1);
    applyStimulus(0, 6'b000000, 0, 5'd0, 0, 1, 0, 1, 6'h05, 32'h028, 1'b0, 1'b0);
    applyStimulus(0, 6'b000000, 1, 5'd0, 0, 0, 0, 1, 6'h04, 32'h020, 1'b0, 1'b0);
    applyStimulus(0, 6'b000000, 1, 5'd2, 0, 0, 0, 1, 6'h00, 32'h000, 1'b0, 1'b0);
    applyStimulus(0, 6'b100000, 0, 5'd0, 0, 1, 0, 1, 6'h20, 32'h100, 1'b1, 1'b1);
    applyStimulus(0, 6'b000000, 1, 5'd6, 1, 0, 0, 0, 6'h20, 32'h100, 1'b1, 1'b0);
    applyStimulus(0, 6'b000000, 1, 5'd31, 1, 0, 0, 1, 6'h20, 32'h100, 1'b1, 1'b1);
    applyStimulus(0, 6'b000000, 1, 5'd4, 1, 0, 0, 1, 6'h30, 32'h180, 1'b1, 1'b1);
    applyStimulus(0, 6'b000000, 1, 5'd4, 0, 0, 0, 1, 6'h20, 32'h100, 1'b1, 1'b1);
    applyStimulus(0, 6'b000000, 1, 5'd5, 0, 1, 0, 1, 6'h00, 32'h000, 1'b0, 1'b0);
    applyStimulus(0, 6'b000000, 0, 5'd0, 0, 1, 1, 1, 6'h00, 32'h000, 1'b1, 1'b1);
    applyStimulus(0, 6'b000000, 0, 5'd0, 0, 1, 0, 1, 6'h00, 32'h000, 1'b0, 1'b0);
    // debug hold: enter, defer wraps 1 and 3, software writes still land
    applyStimulus(1, 6'b000000, 0, 5'd0, 0, 0, 0, 1, 6'h00, 32'h000, 1'b0, 1'b0);
    applyStimulus(1, 6'b000010, 0, 5'd0, 0, 0, 0, 1, 6'h00, 32'h000, 1'b0, 1'b0);
    applyStimulus(1, 6'b001000, 0, 5'd0, 0, 0, 0, 1, 6'h00, 32'h000, 1'b0, 1'b0);
    applyStimulus(1, 6'b000000, 1, 5'd0, 1, 0, 0, 1, 6'h01, 32'h008, 1'b0, 1'b0);
    applyStimulus(1, 6'b000000, 1, 5'd0, 0, 0, 0, 1, 6'h00, 32'h000, 1'b0, 1'b0);
    applyStimulus(0, 6'b000000, 0, 5'd0, 0, 0, 0, 1, 6'h0A, 32'h050, 1'b1, 1'b1);
    applyStimulus(0, 6'b000000, 1, 5'd1, 0, 1, 0, 1, 6'h08, 32'h040, 1'b0, 1'b0);
    applyStimulus(0, 6'b000000, 1, 5'd3, 0, 0, 0, 1, 6'h00, 32'h000, 1'b0, 1'b0);
    // second hold/exit with nothing deferred: stale mask must not replay
    applyStimulus(1, 6'b000000, 0, 5'd0, 0, 0, 0, 1, 6'h00, 32'h000, 1'b0, 1'b0);
    applyStimulus(0, 6'b000000, 0, 5'd0, 0, 0, 0, 1, 6'h00, 32'h000, 1'b0, 1'b0);
    applyStimulus(0, 6'b000000, 0, 5'd0, 0, 0, 0, 1, 6'h00, 32'h000, 1'b0, 1'b0);
    applyStimulus(0, 6'b110000, 0, 5'd0, 0, 0, 0, 1, 6'h30, 32'h180, 1'b1, 1'b1);

    // asynchronous reset in the middle of a cycle
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    checkAllZero("async_reset");
    @(posedge clk_i);
    @(negedge clk_i);
    idleInputs();
    rst_i = 1'b0;
    applyStimulus(0, 6'b000000, 0, 5'd0, 0, 0, 0, 1, 6'h00, 32'h000, 1'b0, 1'b0);
    applyStimulus(0, 6'b000000, 0, 5'd0, 0, 0, 0, 1, 6'h00, 32'h000, 1'b0, 1'b0);
    applyStimulus(0, 6'b000000, 0, 5'd0, 0, 0, 0, 1, 6'h00, 32'h000, 1'b0, 1'b0);

    drain = 0;
    while (sb_q.size() > 0 && drain < 10) begin
      @(posedge clk_i);
      drain++;
    end
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
